uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 35 +++
 rtl/uart_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// UART receiver consumer-side bundle: serial line in, received byte,
// handshake and status flags out. The receiver uses the slave modport,
// whoever drives the line and acknowledges bytes uses the master modport.
interface uart_rx_if;
  logic       rx;
  logic       rdy_clr;
  logic [7:0] dout;
  logic       rdy;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  modport master (
    output rx,
    output rdy_clr,
    input  dout,
    input  rdy,
    input  busy,
    input  frame_err,
    input  overrun,
    input  parity_err
  );

  modport slave (
    input  rx,
    input  rdy_clr,
    output dout,
    output rdy,
    output busy,
    output frame_err,
    output overrun,
    output parity_err
  );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver, 8 data bits, LSB first, one stop bit.
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data
// bits; without it the frame is 8N1 and parity_err is held at 0.
// A stop bit sampled low flags frame_err and parks the receiver in BREAK
// until the line returns high.
module uart_rx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input logic      clk50,
  input logic      rst_n,
  uart_rx_if.slave uart
);

  localparam int DIV   = CLK_HZ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t state_reg, state_next;

  logic             sync_reg;
  logic             rxs_reg;
  logic [1:0]       vld_reg;
  logic             armed_reg;
  logic [DIV_W-1:0] div_reg;
  logic [3:0]       tick_cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       dout_reg;
  logic             rdy_reg;
  logic             overrun_reg;
  logic             frame_err_reg;

  logic tick;
  logic mid_bit;
  logic mid_start;
  logic data_sample;
  logic stop_ok;
  logic stop_bad;
`ifdef UART_RX_PARITY_EN
  logic par_sample;
  logic parity_err_reg;
`endif

  // Divider only runs outside IDLE, so every frame starts from a clean phase.
  assign tick    = (state_reg != IDLE) && (div_reg == DIV_LAST);
  assign mid_bit = tick && (tick_cnt_reg == 4'd15);

  // Two-flop synchronizer; armed_reg blocks start detection until the line
  // has genuinely been seen high after reset (flops reset high are not proof).
  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      sync_reg  <= 1'b1;
      rxs_reg   <= 1'b1;
      vld_reg   <= 2'b00;
      armed_reg <= 1'b0;
    end else begin
      sync_reg <= uart.rx;
      rxs_reg  <= sync_reg;
      vld_reg  <= {vld_reg[0], 1'b1};
      if (vld_reg[1] && rxs_reg) begin
        armed_reg <= 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and per-cycle sampling strobes.
  always_comb begin
    state_next  = state_reg;
    mid_start   = 1'b0;
    data_sample = 1'b0;
    stop_ok     = 1'b0;
    stop_bad    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_sample  = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (armed_reg && !rxs_reg) begin
          state_next = START;
        end
      end
      START: begin
        if (tick && (tick_cnt_reg == 4'd7)) begin
          if (rxs_reg) begin
            state_next = IDLE;
          end else begin
            state_next = DATA;
            mid_start  = 1'b1;
          end
        end
      end
      DATA: begin
        if (mid_bit) begin
          data_sample = 1'b1;
          if (bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (mid_bit) begin
          par_sample = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (mid_bit) begin
          if (rxs_reg) begin
            stop_ok    = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs_reg) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Tick divider, bit-phase counter, data bit counter and shift register.
  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      div_reg      <= '0;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
    end else begin
      if ((state_reg == IDLE) || tick) begin
        div_reg <= '0;
      end else begin
        div_reg <= div_reg + DIV_ONE;
      end
      // Realign to the mid-start point so each later bit lands at count 15.
      if ((state_reg == IDLE) || mid_start) begin
        tick_cnt_reg <= '0;
      end else if (tick) begin
        tick_cnt_reg <= tick_cnt_reg + 4'd1;
      end
      if (mid_start) begin
        bit_cnt_reg <= '0;
      end else if (data_sample) begin
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
      end
      if (data_sample) begin
        shift_reg <= {rxs_reg, shift_reg[7:1]};
      end
    end
  end

  // Byte delivery and sticky flags; a set in the same cycle beats rdy_clr.
  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      dout_reg      <= '0;
      rdy_reg       <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (stop_ok && (!rdy_reg || uart.rdy_clr)) begin
        dout_reg <= shift_reg;
        rdy_reg  <= 1'b1;
      end else if (uart.rdy_clr) begin
        rdy_reg <= 1'b0;
      end
      if (stop_ok && rdy_reg && !uart.rdy_clr) begin
        overrun_reg <= 1'b1;
      end else if (uart.rdy_clr) begin
        overrun_reg <= 1'b0;
      end
      if (stop_bad) begin
        frame_err_reg <= 1'b1;
      end else if (uart.rdy_clr) begin
        frame_err_reg <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: the parity bit must equal the XOR of the eight data bits.
  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      parity_err_reg <= 1'b0;
    end else if (par_sample && (rxs_reg != (^shift_reg))) begin
      parity_err_reg <= 1'b1;
    end else if (uart.rdy_clr) begin
      parity_err_reg <= 1'b0;
    end
  end
  assign uart.parity_err = parity_err_reg;
`else
  assign uart.parity_err = 1'b0;
`endif

  assign uart.dout      = dout_reg;
  assign uart.rdy       = rdy_reg;
  assign uart.busy      = (state_reg != IDLE);
  assign uart.frame_err = frame_err_reg;
  assign uart.overrun   = overrun_reg;

endmodule
